// File: rtl/wave_draw_ctrl.sv
// rtl/wave_draw_ctrl.sv - frame buffer redraw scheduler: clear, then plot one captured waveform
module wave_draw_ctrl #(
    parameter int          WIDTH        = 300,
    parameter int          HEIGHT       = 200,
    parameter logic [11:0] BG_COLOUR    = 12'h000,
    parameter logic [11:0] TRACE_COLOUR = 12'h0F0
) (
    input  logic        clk_vga,
    input  logic        rst,
    input  logic        frame_start,
    input  logic        vga_enb,
    input  logic        capture_ready,
    output logic        capture_ack,
    output logic        busy,
    output logic        smp_en,
    output logic [8:0]  smp_addr,
    input  logic [7:0]  smp_data,
    output logic        fb_we,
    output logic [15:0] fb_addr,
    output logic [11:0] fb_din
);

    localparam logic [15:0] LAST_ADDR = 16'(WIDTH * HEIGHT - 1);
    localparam logic [8:0]  LAST_X    = 9'(WIDTH - 1);
    localparam logic [7:0]  BOTTOM_Y  = 8'(HEIGHT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        PLOT_RD = 3'd2,
        PLOT_WR = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] clr_addr_q, clr_addr_d;
    logic [8:0]  x_q, x_d;
    logic [8:0]  smp_addr_q;
    logic [7:0]  s_q;
    logic [7:0]  s_cur;
    logic        rd_q;
    logic [7:0]  y_drop;
    logic [7:0]  y_plot;
    logic [15:0] plot_addr;

    // The sample arrives the first PLOT_WR cycle; later (stalled) cycles reuse the held copy.
    assign s_cur     = rd_q ? smp_data : s_q;
    assign y_drop    = 8'((16'(s_cur) * 16'(HEIGHT)) >> 8);
    assign y_plot    = BOTTOM_Y - y_drop;
    assign plot_addr = 16'(y_plot) * 16'(WIDTH) + 16'(x_q);

    // State register
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: clear address, plot column, sample request address, held sample
    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            clr_addr_q <= 16'd0;
            x_q        <= 9'd0;
            smp_addr_q <= 9'd0;
            s_q        <= 8'd0;
            rd_q       <= 1'b0;
        end else begin
            clr_addr_q <= clr_addr_d;
            x_q        <= x_d;
            rd_q       <= (state_q == PLOT_RD);
            if (state_d == PLOT_RD) begin
                smp_addr_q <= x_d;
            end
            if (state_q == PLOT_WR) begin
                s_q <= s_cur;
            end
        end
    end

    // Next-state logic; a write state only advances on a cycle the scan-out leaves the port free
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        x_d        = x_q;
        case (state_q)
            IDLE: begin
                if (frame_start && capture_ready) begin
                    state_d    = CLEAR;
                    clr_addr_d = 16'd0;
                end
            end
            CLEAR: begin
                if (!vga_enb) begin
                    if (clr_addr_q == LAST_ADDR) begin
                        state_d = PLOT_RD;
                        x_d     = 9'd0;
                    end else begin
                        clr_addr_d = clr_addr_q + 16'd1;
                    end
                end
            end
            PLOT_RD: begin
                state_d = PLOT_WR;
            end
            PLOT_WR: begin
                if (!vga_enb) begin
                    if (x_q == LAST_X) begin
                        state_d = DONE;
                    end else begin
                        x_d     = x_q + 9'd1;
                        state_d = PLOT_RD;
                    end
                end
            end
            DONE: begin
                state_d    = IDLE;
                clr_addr_d = 16'd0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode; the write strobe is gated by the live vga_enb so it never collides with scan-out
    always_comb begin
        busy        = (state_q != IDLE);
        capture_ack = (state_q == DONE);
        smp_en      = (state_q == PLOT_RD);
        smp_addr    = smp_addr_q;
        fb_we       = ((state_q == CLEAR) || (state_q == PLOT_WR)) && !vga_enb;
        fb_addr     = (state_q == PLOT_WR) ? plot_addr : clr_addr_q;
        fb_din      = 12'h000;
        if (state_q == CLEAR) begin
            fb_din = BG_COLOUR;
        end else if (state_q == PLOT_WR) begin
            fb_din = TRACE_COLOUR;
        end
    end

endmodule
